// File: rtl/seg7_display_arbiter.sv
// Two-requester arbiter and 4-digit scan driver for a shared common-anode seven-segment display.
// Ownership changes and word snapshots happen only at frame boundaries, so a frame never mixes two words.
module seg7_display_arbiter #(
  parameter int SCAN_DIV    = 8192,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] bcd_a,
  input  logic        req_b,
  input  logic [15:0] bcd_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        frame_start,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HC_MAX  = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [HW-1:0] hc_q, hc_d;
  logic          rr_q, rr_d;
  logic [15:0]   buf_q, buf_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          frame_start_q, frame_start_d;
  logic [3:0]    digit_q, digit_d;
  logic [6:0]    display_q, display_d;

  logic          tick_s;
  logic          boundary_s;
  logic          hold_done_s;
  logic [HW:0]   hc_plus_s;

  // Active-low segments; any nibble above 9 falls to the default and shows as 9.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      default: s = 7'b0000100;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nibble_of(input logic [15:0] w, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = w[3:0];
      2'd1:    n = w[7:4];
      2'd2:    n = w[11:8];
      default: n = w[15:12];
    endcase
    return n;
  endfunction

  function automatic logic [3:0] anode_of(input logic [1:0] i);
    logic [3:0] a;
    case (i)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      default: a = 4'b0111;
    endcase
    return a;
  endfunction

  // Scan timing, frame-boundary arbitration, snapshot and pin drive.
  always_comb begin
    tick_s        = (cnt_q == CNT_MAX);
    boundary_s    = tick_s && (idx_q == 2'd3);
    hc_plus_s     = {1'b0, hc_q} + (HW+1)'(1);
    hold_done_s   = (hc_plus_s >= (HW+1)'(HOLD_FRAMES));
    cnt_d         = tick_s ? '0 : cnt_q + CW'(1);
    idx_d         = tick_s ? idx_q + 2'd1 : idx_q;
    state_d       = state_q;
    hc_d          = hc_q;
    rr_d          = rr_q;
    buf_d         = buf_q;
    digit_d       = digit_q;
    display_d     = display_q;
    frame_start_d = boundary_s;

    if (boundary_s) begin
      case (state_q)
        IDLE: begin
          if (req_a && req_b) begin
            state_d = rr_q ? OWN_A : OWN_B;
          end else if (req_a) begin
            state_d = OWN_A;
          end else if (req_b) begin
            state_d = OWN_B;
          end else begin
            state_d = IDLE;
          end
        end
        OWN_A: begin
          if (!req_a) begin
            state_d = req_b ? OWN_B : IDLE;
          end else if (req_b && hold_done_s) begin
            state_d = OWN_B;
          end else begin
            state_d = OWN_A;
          end
        end
        OWN_B: begin
          if (!req_b) begin
            state_d = req_a ? OWN_A : IDLE;
          end else if (req_a && hold_done_s) begin
            state_d = OWN_A;
          end else begin
            state_d = OWN_B;
          end
        end
        default: state_d = IDLE;
      endcase

      // rr holds the last owner (1 = B); dropping to IDLE keeps it.
      if (state_d != state_q) begin
        hc_d = '0;
        if (state_d == OWN_A) begin
          rr_d = 1'b0;
        end else if (state_d == OWN_B) begin
          rr_d = 1'b1;
        end else begin
          rr_d = rr_q;
        end
      end else if (state_q != IDLE) begin
        hc_d = (hc_q == HC_MAX) ? hc_q : hc_q + HW'(1);
      end else begin
        hc_d = '0;
      end

      case (state_d)
        OWN_A:   buf_d = bcd_a;
        OWN_B:   buf_d = bcd_b;
        default: buf_d = buf_q;
      endcase
    end else begin
      state_d = state_q;
    end

    if (tick_s) begin
      if (state_d == IDLE) begin
        digit_d   = 4'b1111;
        display_d = 7'b1111111;
      end else begin
        digit_d   = anode_of(idx_d);
        display_d = seg_of(nibble_of(buf_d, idx_d));
      end
    end else begin
      digit_d   = digit_q;
      display_d = display_q;
    end

    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
  end

  // State and output registers; rr resets to B so A wins the first contested grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= 2'd3;
      hc_q          <= '0;
      rr_q          <= 1'b1;
      buf_q         <= 16'h0000;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      frame_start_q <= 1'b0;
      digit_q       <= 4'b1111;
      display_q     <= 7'b1111111;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      hc_q          <= hc_d;
      rr_q          <= rr_d;
      buf_q         <= buf_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      frame_start_q <= frame_start_d;
      digit_q       <= digit_d;
      display_q     <= display_d;
    end
  end

  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign frame_start = frame_start_q;
  assign DIGIT       = digit_q;
  assign DISPLAY     = display_q;

endmodule
